// File: rtl/vending_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vending_ctrl_multi
//   Multi-product vending machine core. It tracks a credit accumulator, the
//   price and stock count of each item, and valid/ready handshakes towards
//   the dispense mechanism and the change mechanism.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   coin_valid      one-cycle coin strobe; coin_val is sampled with it
//   coin_val        coin value
//   sel_valid       one-cycle purchase request for item sel_idx
//   sel_idx         requested item index
//   cancel          one-cycle refund request
//   restock         reload every stock counter (honoured only when idle)
//   dispense_valid  item waiting for release; held until dispense_ready
//   dispense_idx    index of the item being released
//   dispense_ready  dispense mechanism accepts the item
//   change_valid    one change unit is available
//   change_ready    change mechanism accepts one unit
//   credit          current credit
//   stock           per-item stock, item i at [i*STOCK_W +: STOCK_W]
//   coin_reject     one-cycle pulse: a coin was refused
//   sold_out        one-cycle pulse: the selected item has no stock
//   insufficient    one-cycle pulse: the credit is below the item price
// ---------------------------------------------------------------------------
module vending_ctrl_multi #(
   parameter int NUM_ITEMS   = 4,
   parameter int SEL_W       = 2,
   parameter int CREDIT_W    = 11,
   parameter int MAX_CREDIT  = 1000,
   parameter int CHANGE_UNIT = 50,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
      {11'd500, 11'd300, 11'd200, 11'd150},
   parameter int STOCK_W     = 4,
   parameter int STOCK_INIT  = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           coin_valid,
   input  logic [CREDIT_W-1:0]            coin_val,
   input  logic                           sel_valid,
   input  logic [SEL_W-1:0]               sel_idx,
   input  logic                           cancel,
   input  logic                           restock,
   output logic                           dispense_valid,
   output logic [SEL_W-1:0]               dispense_idx,
   input  logic                           dispense_ready,
   output logic                           change_valid,
   input  logic                           change_ready,
   output logic [CREDIT_W-1:0]            credit,
   output logic [NUM_ITEMS*STOCK_W-1:0]   stock,
   output logic                           coin_reject,
   output logic                           sold_out,
   output logic                           insufficient
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CREDIT,
      ST_DISPENSE,
      ST_CHANGE
   } state_t;

   localparam logic [CREDIT_W:0]   MAX_CREDIT_L  = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] CHANGE_UNIT_L = CREDIT_W'(CHANGE_UNIT);
   localparam logic [STOCK_W-1:0]  STOCK_INIT_L  = STOCK_W'(STOCK_INIT);
   localparam logic [SEL_W:0]      NUM_ITEMS_L   = (SEL_W+1)'(NUM_ITEMS);

   state_t              state_reg, state_next;
   logic [CREDIT_W-1:0] credit_reg, credit_next;
   logic [STOCK_W-1:0]  stock_reg [NUM_ITEMS];
   logic [STOCK_W-1:0]  stock_next [NUM_ITEMS];
   logic                dispense_valid_reg, dispense_valid_next;
   logic [SEL_W-1:0]    dispense_idx_reg, dispense_idx_next;
   logic                change_valid_reg, change_valid_next;
   logic                coin_reject_reg, coin_reject_next;
   logic                sold_out_reg, sold_out_next;
   logic                insufficient_reg, insufficient_next;

   logic [CREDIT_W-1:0] price_arr [NUM_ITEMS];
   logic [CREDIT_W-1:0] sel_price;
   logic [STOCK_W-1:0]  sel_stock;
   logic                sel_in_range;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic                coin_present;
   logic [CREDIT_W-1:0] change_step;

   // Unpack the price table and pack the stock counters onto the output bus.
   generate
      for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
         assign price_arr[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
         assign stock[gi*STOCK_W +: STOCK_W] = stock_reg[gi];
      end
   endgenerate

   // Price and stock of the requested item. An index past the last item
   // reads as zero stock, so it is reported as sold out.
   assign sel_in_range = ({1'b0, sel_idx} < NUM_ITEMS_L);

   always_comb begin
      sel_price = '0;
      sel_stock = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (sel_in_range && sel_idx == SEL_W'(i)) begin
            sel_price = price_arr[i];
            sel_stock = stock_reg[i];
         end
      end
   end

   // One extra bit keeps the ceiling compare free of wrap-around.
   assign coin_sum     = {1'b0, credit_reg} + {1'b0, coin_val};
   assign coin_fits    = (coin_sum <= MAX_CREDIT_L);
   // A zero-value coin is no event at all: no credit change and no pulse.
   assign coin_present = coin_valid && (coin_val != '0);
   // The last change unit may be partial.
   assign change_step  = (credit_reg < CHANGE_UNIT_L) ? credit_reg : CHANGE_UNIT_L;

   always_comb begin
      state_next          = state_reg;
      credit_next         = credit_reg;
      dispense_valid_next = dispense_valid_reg;
      dispense_idx_next   = dispense_idx_reg;
      change_valid_next   = change_valid_reg;
      coin_reject_next    = 1'b0;
      sold_out_next       = 1'b0;
      insufficient_next   = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         stock_next[i] = stock_reg[i];
      end

      case (state_reg)
         ST_IDLE, ST_CREDIT: begin
            if (state_reg == ST_IDLE && restock) begin
               for (int i = 0; i < NUM_ITEMS; i++) begin
                  stock_next[i] = STOCK_INIT_L;
               end
            end

            // A coin that arrives together with a cancel or a selection is
            // never credited; the higher-priority event wins the cycle.
            if ((cancel || sel_valid) && coin_present) begin
               coin_reject_next = 1'b1;
            end

            if (cancel) begin
               if (state_reg == ST_CREDIT) begin
                  if (credit_reg != '0) begin
                     state_next        = ST_CHANGE;
                     change_valid_next = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end else if (sel_valid) begin
               if (state_reg == ST_CREDIT) begin
                  if (sel_stock == '0) begin
                     sold_out_next = 1'b1;
                  end else if (credit_reg < sel_price) begin
                     insufficient_next = 1'b1;
                  end else begin
                     credit_next         = credit_reg - sel_price;
                     dispense_valid_next = 1'b1;
                     dispense_idx_next   = sel_idx;
                     state_next          = ST_DISPENSE;
                     for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (sel_idx == SEL_W'(i)) begin
                           stock_next[i] = stock_reg[i] - 1'b1;
                        end
                     end
                  end
               end
            end else if (coin_present) begin
               if (coin_fits) begin
                  credit_next = coin_sum[CREDIT_W-1:0];
                  state_next  = ST_CREDIT;
               end else begin
                  coin_reject_next = 1'b1;
               end
            end
         end

         ST_DISPENSE: begin
            coin_reject_next = coin_present;
            if (dispense_ready) begin
               dispense_valid_next = 1'b0;
               if (credit_reg != '0) begin
                  state_next        = ST_CHANGE;
                  change_valid_next = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_CHANGE: begin
            coin_reject_next = coin_present;
            if (credit_reg == '0) begin
               change_valid_next = 1'b0;
               state_next        = ST_IDLE;
            end else if (change_valid_reg && change_ready) begin
               credit_next = credit_reg - change_step;
               // change_valid falls in the same update that empties credit.
               if (credit_reg == change_step) begin
                  change_valid_next = 1'b0;
                  state_next        = ST_IDLE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg          <= ST_IDLE;
         credit_reg         <= '0;
         dispense_valid_reg <= 1'b0;
         dispense_idx_reg   <= '0;
         change_valid_reg   <= 1'b0;
         coin_reject_reg    <= 1'b0;
         sold_out_reg       <= 1'b0;
         insufficient_reg   <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_reg[i] <= STOCK_INIT_L;
         end
      end else begin
         state_reg          <= state_next;
         credit_reg         <= credit_next;
         dispense_valid_reg <= dispense_valid_next;
         dispense_idx_reg   <= dispense_idx_next;
         change_valid_reg   <= change_valid_next;
         coin_reject_reg    <= coin_reject_next;
         sold_out_reg       <= sold_out_next;
         insufficient_reg   <= insufficient_next;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_reg[i] <= stock_next[i];
         end
      end
   end

   assign credit         = credit_reg;
   assign dispense_valid = dispense_valid_reg;
   assign dispense_idx   = dispense_idx_reg;
   assign change_valid   = change_valid_reg;
   assign coin_reject    = coin_reject_reg;
   assign sold_out       = sold_out_reg;
   assign insufficient   = insufficient_reg;

endmodule
